// File: rtl/fault_confine_fsm.sv
// fault_confine_fsm: CAN error-state classifier and bus-off recovery sequencer
module fault_confine_fsm #(
   parameter int WARN_LIMIT    = 96,
   parameter int PASSIVE_LIMIT = 128,
   parameter bit AUTO_RECOVER  = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [8:0] tec,
   input  logic [7:0] rec,
   input  logic       erb_eq128,
   input  logic       recover_req,
   output logic       count_reset_n,
   output logic       erroractive,
   output logic       errorpassive,
   output logic       busoff,
   output logic       warning,
   output logic       state_chg
);
   typedef enum logic [2:0] {ERR_ACTIVE, ERR_PASSIVE, BO_WAIT, BO_COUNT, BO_CLEAR} state_t;
   state_t state, next_state;
   logic pas, bo, warn_cmp, next_act, next_pas, next_bo;
   // next-state decode; outputs are registered from the upcoming state
   always_comb begin
      pas = int'(tec) >= PASSIVE_LIMIT || int'(rec) >= PASSIVE_LIMIT;
      bo = tec[8];
      warn_cmp = int'(tec) >= WARN_LIMIT || int'(rec) >= WARN_LIMIT;
      next_state = state;
      case (state)
         ERR_ACTIVE, ERR_PASSIVE: next_state = bo ? BO_WAIT : pas ? ERR_PASSIVE : ERR_ACTIVE;
         BO_WAIT: next_state = (AUTO_RECOVER || recover_req) ? BO_COUNT : BO_WAIT;
         BO_COUNT: next_state = erb_eq128 ? BO_CLEAR : BO_COUNT;
         default: next_state = ERR_ACTIVE;
      endcase
      next_act = next_state == ERR_ACTIVE;
      next_pas = next_state == ERR_PASSIVE;
      next_bo = !next_act && !next_pas;
   end
   // state and registered status; warning is suppressed while counters are being cleared
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= ERR_ACTIVE;
         erroractive <= 1'b1;
         errorpassive <= 1'b0;
         busoff <= 1'b0;
         warning <= 1'b0;
         state_chg <= 1'b0;
         count_reset_n <= 1'b0;
      end else begin
         state <= next_state;
         erroractive <= next_act;
         errorpassive <= next_pas;
         busoff <= next_bo;
         state_chg <= {next_act, next_pas, next_bo} != {erroractive, errorpassive, busoff};
         warning <= !next_bo && state != BO_CLEAR && warn_cmp;
         count_reset_n <= !(next_state == BO_WAIT || next_state == BO_CLEAR);
      end
   end
endmodule

// File: tb/tb_fault_confine_fsm.sv
// tb_fault_confine_fsm: model-checked bench for both recovery modes of fault_confine_fsm
module tb_fault_confine_fsm;
   logic clock = 1'b0;
   logic reset, erb_eq128, recover_req;
   logic [8:0] tec;
   logic [7:0] rec;
   logic crn[2], act[2], pas[2], bo[2], warn[2], chg[2];
   int n_cmp = 0, n_bad = 0;
   int m_mode[2];
   bit m_allowed[2], m_clearing[2];
   bit m_valid = 1'b0;
   bit e_crn[2], e_act[2], e_pas[2], e_bo[2], e_warn[2], e_chg[2];

   always #5 clock = ~clock;

   fault_confine_fsm #(.AUTO_RECOVER(1'b1)) dut_a (
      .clock(clock), .reset(reset), .tec(tec), .rec(rec), .erb_eq128(erb_eq128),
      .recover_req(recover_req), .count_reset_n(crn[0]), .erroractive(act[0]),
      .errorpassive(pas[0]), .busoff(bo[0]), .warning(warn[0]), .state_chg(chg[0]));

   fault_confine_fsm #(.AUTO_RECOVER(1'b0)) dut_m (
      .clock(clock), .reset(reset), .tec(tec), .rec(rec), .erb_eq128(erb_eq128),
      .recover_req(recover_req), .count_reset_n(crn[1]), .erroractive(act[1]),
      .errorpassive(pas[1]), .busoff(bo[1]), .warning(warn[1]), .state_chg(chg[1]));

   task automatic check(input string nm, input logic a, input logic e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", nm, a, e, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   // reference: mode 0 active, 1 passive, 2 bus-off; bus-off tracked as waiting/counting/clearing
   always @(posedge clock) begin
      int prev;
      bit was_clr;
      for (int k = 0; k < 2; k++) begin
         prev = m_mode[k];
         was_clr = m_clearing[k];
         if (!reset) begin
            m_mode[k] = 0;
            m_allowed[k] = 0;
            m_clearing[k] = 0;
            e_warn[k] = 0;
            e_chg[k] = 0;
            e_crn[k] = 0;
         end else begin
            if (prev != 2) begin
               m_mode[k] = tec >= 256 ? 2 : (tec >= 128 || rec >= 128) ? 1 : 0;
               m_allowed[k] = 0;
               m_clearing[k] = 0;
            end else if (was_clr) begin
               m_mode[k] = 0;
               m_clearing[k] = 0;
            end else if (m_allowed[k]) m_clearing[k] = erb_eq128;
            else m_allowed[k] = (k == 0) || recover_req;
            e_chg[k] = m_mode[k] != prev;
            e_warn[k] = m_mode[k] != 2 && !was_clr && (tec >= 96 || rec >= 96);
            e_crn[k] = !(m_mode[k] == 2 && (!m_allowed[k] || m_clearing[k]));
         end
         e_act[k] = m_mode[k] == 0;
         e_pas[k] = m_mode[k] == 1;
         e_bo[k] = m_mode[k] == 2;
      end
      m_valid = 1'b1;
   end

   // every-cycle comparison of both instances against the reference
   always @(negedge clock) begin
      if (m_valid) for (int k = 0; k < 2; k++) begin
         string p;
         p = k == 0 ? "auto" : "manual";
         check({p, ".erroractive"}, act[k], e_act[k]);
         check({p, ".errorpassive"}, pas[k], e_pas[k]);
         check({p, ".busoff"}, bo[k], e_bo[k]);
         check({p, ".warning"}, warn[k], e_warn[k]);
         check({p, ".state_chg"}, chg[k], e_chg[k]);
         check({p, ".count_reset_n"}, crn[k], e_crn[k]);
      end
   end

   initial begin
      reset = 1'b0; tec = '0; rec = '0; erb_eq128 = 1'b0; recover_req = 1'b0;
      step(3);
      check("lit.reset_active", act[0], 1'b1);
      check("lit.reset_crn", crn[0], 1'b0);
      check("lit.reset_chg", chg[0], 1'b0);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         check("lit.idle_active", act[0], 1'b1);
         check("lit.idle_crn", crn[0], 1'b1);
         check("lit.idle_warn", warn[0], 1'b0);
      end
      rec = 8'd96; step(1);
      check("lit.warn96", warn[0], 1'b1);
      rec = 8'd128; step(1);
      check("lit.passive", pas[0], 1'b1);
      check("lit.passive_chg", chg[0], 1'b1);
      step(1);
      check("lit.chg_one_cycle", chg[0], 1'b0);
      rec = 8'd127; step(1);
      check("lit.back_active", act[0], 1'b1);
      check("lit.back_chg", chg[0], 1'b1);
      rec = 8'd128; step(1);
      tec = 9'd256; step(1);
      check("lit.busoff", bo[0], 1'b1);
      check("lit.busoff_chg", chg[0], 1'b1);
      check("lit.bo_wait_crn", crn[0], 1'b0);
      step(1);
      check("lit.bo_count_crn", crn[0], 1'b1);
      check("lit.bo_count_chg", chg[0], 1'b0);
      check("lit.manual_wait_crn", crn[1], 1'b0);
      for (int i = 0; i < 50; i++) begin
         tec = 9'($urandom_range(0, 511)); rec = 8'($urandom_range(0, 255));
         step(1);
         check("lit.bo_hold", bo[0], 1'b1);
      end
      tec = '0; rec = 8'd100; erb_eq128 = 1'b1; step(1);
      check("lit.bo_clear_crn", crn[0], 1'b0);
      check("lit.bo_clear_busoff", bo[0], 1'b1);
      erb_eq128 = 1'b0; step(1);
      check("lit.recovered", act[0], 1'b1);
      check("lit.recovered_crn", crn[0], 1'b1);
      check("lit.recovered_chg", chg[0], 1'b1);
      check("lit.recovered_warn", warn[0], 1'b0);
      step(1);
      check("lit.warn_after", warn[0], 1'b1);
      for (int i = 0; i < 100; i++) begin
         tec = 9'($urandom_range(0, 511)); rec = 8'($urandom_range(0, 255));
         erb_eq128 = 1'($urandom_range(0, 1));
         step(1);
         check("lit.manual_hold_crn", crn[1], 1'b0);
         check("lit.manual_hold_bo", bo[1], 1'b1);
      end
      erb_eq128 = 1'b0; recover_req = 1'b1; step(1);
      check("lit.manual_count", crn[1], 1'b1);
      recover_req = 1'b0; erb_eq128 = 1'b1; step(1);
      check("lit.manual_clear", crn[1], 1'b0);
      erb_eq128 = 1'b0; tec = '0; rec = '0; step(1);
      check("lit.manual_recovered", act[1], 1'b1);
      check("lit.manual_chg", chg[1], 1'b1);
      reset = 1'b0; step(1);
      reset = 1'b1; step(2);
      tec = 9'd256; step(1);
      tec = '0; step(1);
      check("lit.pre_reset_count", crn[0], 1'b1);
      reset = 1'b0; step(1);
      check("lit.midrec_active", act[0], 1'b1);
      check("lit.midrec_busoff", bo[0], 1'b0);
      check("lit.midrec_crn", crn[0], 1'b0);
      reset = 1'b1; step(2);
      check("lit.pre_direct", act[0], 1'b1);
      tec = 9'd300; step(1);
      check("lit.direct_bo", bo[0], 1'b1);
      check("lit.direct_no_pas", pas[0], 1'b0);
      check("lit.direct_chg", chg[0], 1'b1);
      for (int i = 0; i < 3000; i++) begin
         tec = $urandom_range(0, 99) < 4 ? 9'($urandom_range(256, 511)) : 9'($urandom_range(0, 200));
         rec = 8'($urandom_range(0, 255));
         erb_eq128 = $urandom_range(0, 9) == 0;
         recover_req = $urandom_range(0, 4) == 0;
         reset = $urandom_range(0, 99) != 0;
         step(1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
